// File: rtl/bit_stat_pkg.sv
// Shared types and helpers for the bit-statistics counter.
// Holds the FSM state encoding and the width-agnostic saturating adder.
package bit_stat_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } bst_state_t;

    // Saturating add of two values into a w-bit total (w < 64).
    // The clamp flag is packed at bit w, just above the w-bit result,
    // so a caller keeps the low w+1 bits: {sat, sum}.
    function automatic logic [64:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned w
    );
        logic [64:0] full;
        logic [64:0] max_v;
        logic [64:0] res;
        full  = {1'b0, a} + {1'b0, b};
        max_v = (65'd1 << w) - 65'd1;
        if (full > max_v) begin
            res    = max_v;
            res[w] = 1'b1;
        end else begin
            res = full;
        end
        return res;
    endfunction

endpackage

// File: rtl/chunk_popcount.sv
// Combinational population count of one CHUNK-bit slice.
// Result width is just wide enough to hold CHUNK.
module chunk_popcount #(
    parameter  int CHUNK = 4,
    localparam int PW    = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] i_bits,
    output logic [PW-1:0]    o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            o_count = o_count + PW'(i_bits[i]);
        end
    end

endmodule

// File: rtl/bit_stat_counter.sv
// Multi-cycle ones/zeroes counter with valid/ready on both sides.
// Counts CHUNK bits per cycle and keeps saturating running totals.
module bit_stat_counter
    import bit_stat_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int CHUNK = 4,
    parameter  int ACC_W = 16,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_accum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    word_ones,
    output logic [CW-1:0]    word_zeroes,
    output logic [ACC_W-1:0] acc_ones,
    output logic [ACC_W-1:0] acc_zeroes,
    output logic             acc_sat
);

    localparam int K  = WIDTH / CHUNK;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = $clog2(CHUNK + 1);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
            $error("bit_stat_counter: CHUNK must be in 1..WIDTH");
        end
        if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("bit_stat_counter: WIDTH must be a multiple of CHUNK");
        end
        if (ACC_W < CW || ACC_W > 63) begin : g_bad_acc
            $error("bit_stat_counter: ACC_W must be in CW..63");
        end
    endgenerate

    bst_state_t       r_state;
    logic [WIDTH-1:0] r_shift;
    logic             r_accum;
    logic [KW-1:0]    r_chunk_cnt;
    logic [CW-1:0]    r_word_cnt;
    logic             r_out_valid;
    logic [CW-1:0]    r_word_ones;
    logic [CW-1:0]    r_word_zeroes;
    logic [ACC_W-1:0] r_acc_ones;
    logic [ACC_W-1:0] r_acc_zeroes;
    logic             r_acc_sat;

    logic [PW-1:0]    w_pop;
    logic [CW-1:0]    w_word_total;
    logic [CW-1:0]    w_word_zero;
    logic             w_last;
    logic [ACC_W:0]   w_ones_res;
    logic [ACC_W:0]   w_zero_res;

    chunk_popcount #(
        .CHUNK   (CHUNK)
    ) u_pop (
        .i_bits  (r_shift[CHUNK-1:0]),
        .o_count (w_pop)
    );

    // Word total including the chunk being counted this cycle.
    assign w_word_total = r_word_cnt + CW'(w_pop);
    assign w_word_zero  = CW'(WIDTH) - w_word_total;
    assign w_last       = (r_chunk_cnt == KW'(K - 1));

    assign w_ones_res = (ACC_W + 1)'(sat_add(64'(r_acc_ones), 64'(w_word_total), ACC_W));
    assign w_zero_res = (ACC_W + 1)'(sat_add(64'(r_acc_zeroes), 64'(w_word_zero), ACC_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_accum       <= 1'b0;
            r_chunk_cnt   <= '0;
            r_word_cnt    <= '0;
            r_out_valid   <= 1'b0;
            r_word_ones   <= '0;
            r_word_zeroes <= '0;
            r_acc_ones    <= '0;
            r_acc_zeroes  <= '0;
            r_acc_sat     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift     <= in_data;
                        r_accum     <= in_accum;
                        r_chunk_cnt <= '0;
                        r_word_cnt  <= '0;
                        r_state     <= COUNT;
                    end
                end
                COUNT: begin
                    r_word_cnt  <= w_word_total;
                    r_shift     <= r_shift >> CHUNK;
                    r_chunk_cnt <= r_chunk_cnt + KW'(1);
                    if (w_last) begin
                        r_word_ones   <= w_word_total;
                        r_word_zeroes <= w_word_zero;
                        if (r_accum) begin
                            r_acc_ones   <= w_ones_res[ACC_W-1:0];
                            r_acc_zeroes <= w_zero_res[ACC_W-1:0];
                            r_acc_sat    <= r_acc_sat | w_ones_res[ACC_W] | w_zero_res[ACC_W];
                        end else begin
                            r_acc_ones   <= ACC_W'(w_word_total);
                            r_acc_zeroes <= ACC_W'(w_word_zero);
                            r_acc_sat    <= 1'b0;
                        end
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE) && !rst;
    assign out_valid   = r_out_valid;
    assign word_ones   = r_word_ones;
    assign word_zeroes = r_word_zeroes;
    assign acc_ones    = r_acc_ones;
    assign acc_zeroes  = r_acc_zeroes;
    assign acc_sat     = r_acc_sat;

endmodule
